// File: rtl/logic_station_multilane_if.sv
// Issue and commit bundle for the multilane logic station.
// LOGIC_STATION_ZERO_FLAG_EN adds the per-lane oCommitZero flags.
interface logic_station_multilane_if #(
    parameter int LANES     = 3,
    parameter int WIDTH     = 32,
    parameter int DST_WIDTH = 8
);
    logic                   iIssueValid;
    logic                   oIssueReady;
    logic [2:0]             iOp;
    logic [LANES*WIDTH-1:0] iSrcA;
    logic [LANES*WIDTH-1:0] iSrcB;
    logic [DST_WIDTH-1:0]   iDst;
    logic [LANES-1:0]       iWE;
    logic [3:0]             iId;
    logic                   oCommitRequest;
    logic                   iCommitGranted;
    logic [3:0]             oCommitId;
    logic [DST_WIDTH-1:0]   oCommitDst;
    logic [LANES-1:0]       oCommitWE;
    logic [LANES*WIDTH-1:0] oCommitResult;
    logic                   oBusy;
`ifdef LOGIC_STATION_ZERO_FLAG_EN
    logic [LANES-1:0]       oCommitZero;
`endif

    modport master (
`ifdef LOGIC_STATION_ZERO_FLAG_EN
        input  oCommitZero,
`endif
        output iIssueValid, iOp, iSrcA, iSrcB,
        output iDst, iWE, iId, iCommitGranted,
        input  oIssueReady, oCommitRequest,
        input  oCommitId, oCommitDst, oCommitWE,
        input  oCommitResult, oBusy
    );

    modport slave (
`ifdef LOGIC_STATION_ZERO_FLAG_EN
        output oCommitZero,
`endif
        input  iIssueValid, iOp, iSrcA, iSrcB,
        input  iDst, iWE, iId, iCommitGranted,
        output oIssueReady, oCommitRequest,
        output oCommitId, oCommitDst, oCommitWE,
        output oCommitResult, oBusy
    );
endinterface

// File: rtl/logic_station_multilane.sv
// LANES x WIDTH bitwise logic station: exec register feeding a commit FIFO.
// Optional LOGIC_STATION_ZERO_FLAG_EN stores per-lane zero flags per entry.
module logic_station_multilane #(
    parameter int LANES     = 3,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 2,
    parameter int DST_WIDTH = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    logic_station_multilane_if.slave  bus
);
    localparam int LW    = LANES * WIDTH;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    localparam ptr_t LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    function automatic ptr_t f_inc(input ptr_t p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [LW-1:0]        w_result;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_nonempty;
    logic [CNT_W:0]       w_occ;

    logic                 r_s_valid;
    logic [LW-1:0]        r_s_result;
    logic [DST_WIDTH-1:0] r_s_dst;
    logic [LANES-1:0]     r_s_we;
    logic [3:0]           r_s_id;

    logic [LW-1:0]        r_fifo_res [DEPTH];
    logic [DST_WIDTH-1:0] r_fifo_dst [DEPTH];
    logic [LANES-1:0]     r_fifo_we  [DEPTH];
    logic [3:0]           r_fifo_id  [DEPTH];
    ptr_t                 r_wr_ptr;
    ptr_t                 r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    // Ops are lane-independent bitwise functions, so the whole bus is one op.
    always_comb begin
        w_result = '0;
        unique case (bus.iOp)
            3'b000: w_result = bus.iSrcA & bus.iSrcB;
            3'b001: w_result = bus.iSrcA | bus.iSrcB;
            3'b010: w_result = bus.iSrcA ^ bus.iSrcB;
            3'b011: w_result = ~bus.iSrcA;
            3'b100: w_result = ~(bus.iSrcA & bus.iSrcB);
            3'b101: w_result = ~(bus.iSrcA | bus.iSrcB);
            3'b110: w_result = ~(bus.iSrcA ^ bus.iSrcB);
            3'b111: w_result = bus.iSrcA;
        endcase
    end

    // Ready looks only at registered occupancy; a pop this cycle is not bypassed.
    assign w_occ      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s_valid};
    assign w_ready    = (w_occ < DEPTH_V);
    assign w_accept   = bus.iIssueValid & w_ready;
    assign w_nonempty = (r_count != '0);
    assign w_push     = r_s_valid;
    assign w_pop      = w_nonempty & bus.iCommitGranted;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_s_valid  <= 1'b0;
            r_s_result <= '0;
            r_s_dst    <= '0;
            r_s_we     <= '0;
            r_s_id     <= '0;
        end else begin
            r_s_valid <= w_accept;
            if (w_accept) begin
                r_s_result <= w_result;
                r_s_dst    <= bus.iDst;
                r_s_we     <= bus.iWE;
                r_s_id     <= bus.iId;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_res[i] <= '0;
                r_fifo_dst[i] <= '0;
                r_fifo_we[i]  <= '0;
                r_fifo_id[i]  <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_res[r_wr_ptr] <= r_s_result;
                r_fifo_dst[r_wr_ptr] <= r_s_dst;
                r_fifo_we[r_wr_ptr]  <= r_s_we;
                r_fifo_id[r_wr_ptr]  <= r_s_id;
                r_wr_ptr             <= f_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef LOGIC_STATION_ZERO_FLAG_EN
    logic [LANES-1:0] w_zero;
    logic [LANES-1:0] r_s_zero;
    logic [LANES-1:0] r_fifo_zero [DEPTH];

    always_comb begin
        w_zero = '0;
        for (int l = 0; l < LANES; l++) begin
            w_zero[l] = (w_result[l*WIDTH +: WIDTH] == '0);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_s_zero <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_zero[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_s_zero <= w_zero;
            end
            if (w_push) begin
                r_fifo_zero[r_wr_ptr] <= r_s_zero;
            end
        end
    end

    assign bus.oCommitZero = w_nonempty ? r_fifo_zero[r_rd_ptr] : '0;
`endif

    assign bus.oIssueReady    = w_ready;
    assign bus.oCommitRequest = w_nonempty;
    assign bus.oCommitResult  = w_nonempty ? r_fifo_res[r_rd_ptr] : '0;
    assign bus.oCommitDst     = w_nonempty ? r_fifo_dst[r_rd_ptr] : '0;
    assign bus.oCommitWE      = w_nonempty ? r_fifo_we[r_rd_ptr]  : '0;
    assign bus.oCommitId      = w_nonempty ? r_fifo_id[r_rd_ptr]  : '0;
    assign bus.oBusy          = r_s_valid | w_nonempty;
endmodule

// File: tb/tb_logic_station_multilane.sv
// Scoreboard bench for logic_station_multilane: directed cases then
// random issue/grant traffic checked against a bitwise reference model.
module tb_logic_station_multilane;
    localparam int LANES = 3;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int DSTW  = 8;
    localparam int LW    = LANES * WIDTH;

    typedef struct {
        logic [LW-1:0]    res;
        logic [DSTW-1:0]  dst;
        logic [LANES-1:0] we;
        logic [3:0]       id;
        logic [LANES-1:0] zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_done;
    exp_t q[$];

    logic_station_multilane_if #(
        .LANES(LANES), .WIDTH(WIDTH), .DST_WIDTH(DSTW)
    ) bus ();

    logic_station_multilane #(
        .LANES(LANES), .WIDTH(WIDTH),
        .DEPTH(DEPTH), .DST_WIDTH(DSTW)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each opcode is a plain bitwise function of the operands.
    function automatic logic [LW-1:0] model(input logic [2:0] op,
                                            input logic [LW-1:0] a,
                                            input logic [LW-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~a;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [LW-1:0] a,
                         input logic [LW-1:0] b, input logic [DSTW-1:0] dst,
                         input logic [LANES-1:0] we, input logic [3:0] id);
        exp_t e;
        int   waited = 0;
        bus.iOp = op;
        bus.iSrcA = a;
        bus.iSrcB = b;
        bus.iDst = dst;
        bus.iWE = we;
        bus.iId = id;
        bus.iIssueValid = 1'b1;
        forever begin
            chk("issue_ready", 128'(bus.oIssueReady),
                128'(q.size() < DEPTH));
            if (bus.oIssueReady) begin
                e.res = model(op, a, b);
                e.dst = dst;
                e.we = we;
                e.id = id;
                for (int l = 0; l < LANES; l++) begin
                    e.zero[l] = (e.res[l*WIDTH +: WIDTH] == '0);
                end
                q.push_back(e);
                step();
                break;
            end
            step();
            waited++;
            if (waited > 50) begin
                chk("issue_timeout", 128'(waited), 128'(0));
                break;
            end
        end
        bus.iIssueValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.iCommitGranted = 1'b1;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        step();
        chk("drain_empty", 128'(q.size()), 128'(0));
        bus.iCommitGranted = 1'b0;
        chk("drain_busy", 128'(bus.oBusy), 128'(0));
        chk("drain_ready", 128'(bus.oIssueReady), 128'(1));
    endtask

    // Monitor: pop the scoreboard on every granted commit.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.oCommitRequest && bus.iCommitGranted) begin
                if (q.size() == 0) begin
                    chk("commit_unexpected", 128'(1), 128'(0));
                end else begin
                    e = q.pop_front();
                    chk("commit_result", 128'(bus.oCommitResult),
                        128'(e.res));
                    chk("commit_dst", 128'(bus.oCommitDst), 128'(e.dst));
                    chk("commit_we", 128'(bus.oCommitWE), 128'(e.we));
                    chk("commit_id", 128'(bus.oCommitId), 128'(e.id));
`ifdef LOGIC_STATION_ZERO_FLAG_EN
                    chk("commit_zero", 128'(bus.oCommitZero),
                        128'(e.zero));
`endif
                end
            end else if (!bus.oCommitRequest) begin
                chk("idle_outputs",
                    128'({bus.oCommitResult, bus.oCommitDst,
                          bus.oCommitWE, bus.oCommitId}), 128'(0));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        logic [2:0]    ops [4];
        ops[0] = 3'b001;
        ops[1] = 3'b010;
        ops[2] = 3'b011;
        ops[3] = 3'b110;
        bus.iIssueValid = 1'b0;
        bus.iOp = '0;
        bus.iSrcA = '0;
        bus.iSrcB = '0;
        bus.iDst = '0;
        bus.iWE = '0;
        bus.iId = '0;
        bus.iCommitGranted = 1'b0;
        step();
        step();
        chk("reset_request", 128'(bus.oCommitRequest), 128'(0));
        chk("reset_busy", 128'(bus.oBusy), 128'(0));
        chk("reset_result", 128'(bus.oCommitResult), 128'(0));
        rst = 1'b0;
        step();
        chk("reset_ready", 128'(bus.oIssueReady), 128'(1));

        // Basic AND with latency and hold-without-grant checks.
        issue(3'b000, {3{32'hF0F0F0F0}}, {3{32'hFF00FF00}},
              8'hA5, 3'b111, 4'h9);
        step();
        chk("lat_request", 128'(bus.oCommitRequest), 128'(1));
        chk("lat_result", 128'(bus.oCommitResult),
            128'({3{32'hF000F000}}));
        chk("lat_dst_id", 128'({bus.oCommitDst, bus.oCommitId}),
            128'({8'hA5, 4'h9}));
        chk("lat_we", 128'(bus.oCommitWE), 128'(3'b111));
        step();
        chk("hold_result", 128'(bus.oCommitResult),
            128'({3{32'hF000F000}}));
        drain();

        // Back-to-back ops, grant held high, order via scoreboard.
        bus.iCommitGranted = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], {$urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom},
                  8'(i + 16), 3'(i + 1), 4'(i));
        end
        drain();

        // Fill with grant low; a single grant lets the held op in.
        issue(3'b101, {$urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom}, 8'h11, 3'b001, 4'h1);
        issue(3'b100, {$urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom}, 8'h22, 3'b010, 4'h2);
        chk("full_ready", 128'(bus.oIssueReady), 128'(0));
        fork
            issue(3'b111, {$urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom}, 8'h33, 3'b100, 4'h3);
            begin
                step();
                step();
                step();
                bus.iCommitGranted = 1'b1;
                step();
                bus.iCommitGranted = 1'b0;
            end
        join
        drain();

        // Grant with nothing queued must change nothing.
        bus.iCommitGranted = 1'b1;
        step();
        bus.iCommitGranted = 1'b0;
        chk("empty_grant_req", 128'(bus.oCommitRequest), 128'(0));
        chk("empty_grant_busy", 128'(bus.oBusy), 128'(0));

        // Reset while occupied clears everything at once.
        issue(3'b010, {$urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom}, 8'h44, 3'b111, 4'h4);
        issue(3'b001, {$urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom}, 8'h55, 3'b111, 4'h5);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_request", 128'(bus.oCommitRequest), 128'(0));
        chk("rst_busy", 128'(bus.oBusy), 128'(0));
        chk("rst_outputs",
            128'({bus.oCommitResult, bus.oCommitDst,
                  bus.oCommitWE, bus.oCommitId}), 128'(0));
        q.delete();
        step();
        rst = 1'b0;
        step();
        chk("rst_ready", 128'(bus.oIssueReady), 128'(1));
        issue(3'b110, {$urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom}, 8'h66, 3'b011, 4'h6);
        drain();

`ifdef LOGIC_STATION_ZERO_FLAG_EN
        issue(3'b000, {32'h1, 32'h1, 32'h0000FFFF},
              {32'h1, 32'h1, 32'hFFFF0000}, 8'h77, 3'b111, 4'h7);
        step();
        chk("zero_flag", 128'(bus.oCommitZero), 128'(3'b001));
        drain();
`endif

        // Random traffic with random grants.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    a = {$urandom, $urandom, $urandom};
                    b = {$urandom, $urandom, $urandom};
                    if ($urandom_range(0, 7) == 0) begin
                        b = a;
                    end
                    issue(3'($urandom_range(0, 7)), a, b,
                          8'($urandom), 3'($urandom), 4'($urandom));
                    repeat ($urandom_range(0, 2)) step();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    bus.iCommitGranted = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
